// File: rtl/mult_operand_sequencer.sv
// Operand queue, start/done handshake and product register around a
// single-issue sequential multiplier.
module mult_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mult_start,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic               mult_done,
    input  logic [2*WIDTH-1:0] mult_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    logic [WIDTH-1:0] qa [DEPTH];
    logic [WIDTH-1:0] qb [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] issue_a;
    logic [WIDTH-1:0] issue_b;

    logic push;
    logic pop;
    logic issue_go;
    logic consume;

    // in_ready is taken from the pre-pop count, so a full queue never
    // bypasses a slot freed in the same cycle.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == ISSUE) && !mult_done;
    assign issue_go = (state == IDLE) && (state_nx == ISSUE);
    assign consume  = out_valid && out_ready;

    assign mult_start = (state == ISSUE);
    assign mult_a     = issue_a;
    assign mult_b     = issue_b;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if ((count != '0) && (!out_valid || out_ready))
                    state_nx = ISSUE;
            end
            ISSUE: begin
                if (!mult_done)
                    state_nx = RUN;
            end
            RUN: begin
                if (mult_done)
                    state_nx = CAPTURE;
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qa[wptr] <= in_a;
            qb[wptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            state       <= IDLE;
            issue_a     <= '0;
            issue_b     <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            state <= state_nx;

            // Operands stay frozen from issue until the next issue.
            if (issue_go) begin
                issue_a <= qa[rptr];
                issue_b <= qb[rptr];
            end

            if (state == CAPTURE) begin
                out_product <= mult_product;
                out_valid   <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
